moxie_wb_arbiter: RTL and testbench
===================================

MOXIE_WB_ARBITER -- requirements
Module: moxie_wb_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, cycles a granted transfer may wait for ack before it is aborted (range 1..1023).
REQ-002 Port: clk_i  input  1  core clock; one clock domain, all logic on rising edge.
REQ-003 Port: rst_i  input  1  synchronous, active-high reset.
REQ-004 Ports (instruction master, read-only): wbm_I_cyc_i, wbm_I_stb_i in 1; wbm_I_adr_i in 32; wbm_I_dat_o out 16; wbm_I_ack_o, wbm_I_err_o out 1.
REQ-005 Ports (data master): wbm_D_cyc_i, wbm_D_stb_i, wbm_D_we_i in 1; wbm_D_sel_i in 2; wbm_D_adr_i in 32; wbm_D_dat_i in 16; wbm_D_dat_o out 16; wbm_D_ack_o, wbm_D_err_o out 1.
REQ-006 Ports (shared slave bus): wbs_cyc_o, wbs_stb_o, wbs_we_o out 1; wbs_sel_o out 2; wbs_adr_o out 32; wbs_dat_o out 16; wbs_dat_i in 16; wbs_ack_i in 1.
REQ-007 Port: grant_o  output  2  one-hot current owner, bit0 = I, bit1 = D; 2'b00 when idle.

Function
REQ-008 FSM states IDLE, GNT_I, GNT_D; state and grant are registered.
REQ-009 IDLE: only I cyc -> GNT_I; only D cyc -> GNT_D; both -> the master not served last (round-robin); neither -> stay IDLE.
REQ-010 Last-served flag resets to D, so the first contention after reset goes to I.
REQ-011 Grant latency: exactly one cycle from master cyc rising in IDLE to wbs_cyc_o high.
REQ-012 GNT_x is held while that master's cyc stays high, regardless of the other master's requests (bus lock across multi-beat cycles).
REQ-013 GNT_x -> IDLE on the cycle after the owner's cyc drops; a new grant is issued no earlier than the following cycle, giving a minimum of one idle cycle between owners.
REQ-014 Slave-bus outputs are combinational muxes of the owner's signals; in IDLE, cyc/stb/we/sel drive 0 and adr/dat drive 0.
REQ-015 Under GNT_I: wbs_we_o = 0 and wbs_sel_o = 2'b11.
REQ-016 wbs_dat_i fans out to both wbm_*_dat_o unconditionally.
REQ-017 wbs_ack_i is routed only to the owner's ack; the non-owner's ack and err are always 0.
REQ-018 Watchdog counter clears on every grant and on every ack, and increments each cycle the owner has stb high with no ack.
REQ-019 When the counter reaches TIMEOUT_CYCLES: owner err pulses for exactly one cycle, wbs_cyc_o/stb_o are forced low that cycle, FSM goes to IDLE, and last-served is updated to the aborted owner.
REQ-020 If ack and timeout coincide, ack wins: no err, counter clears.
REQ-021 Counter width is ceil(log2(TIMEOUT_CYCLES+1)); it saturates and never wraps.
REQ-022 ack and err are never asserted in the same cycle on either master.

Reset
REQ-023 While rst_i is high: state = IDLE, grant_o = 0, counter = 0, last-served = D, all slave-bus control outputs = 0, all ack/err = 0.
REQ-024 Reset asserted during an active transfer abandons it with no err pulse; an ack arriving during reset is dropped.

Structure
REQ-025 FSM state encodings and the TIMEOUT_CYCLES default value live in the shared defines header used by the core.
REQ-026 The watchdog is one sub-module, wb_watchdog (inputs clear, count_en; output expired), instantiated once.
REQ-027 moxie_wb_arbiter replaces the combinational arbitration at core top level; the core's I and D ports connect directly to it.

Verification
REQ-028 Only I cyc at cycle 0 with adr 0x1000 -> wbs_cyc_o high at cycle 1, wbs_adr_o = 0x1000, we = 0, sel = 11; ack at cycle 3 -> wbm_I_ack_o high at cycle 3, wbm_D_ack_o low.
REQ-029 I and D cyc both rise on the first cycle after reset -> I granted first; when I drops, D is granted two cycles later; on the next contention D is served before I.
REQ-030 D holds cyc for 4 beats (we = 1, sel = 01, dat = 0xBEEF) while I requests continuously -> grant_o stays 2'b10 through all 4 acks and I waits.
REQ-031 TIMEOUT_CYCLES = 4, D stb with no ack -> wbm_D_err_o is a single pulse exactly 4 cycles after stb, wbs_cyc_o low that cycle, then the FSM returns to IDLE.
REQ-032 Ack on the same cycle the counter would expire -> ack delivered, no err.
REQ-033 rst_i asserted mid-transfer under GNT_I -> next cycle grant_o = 0, wbs_cyc_o = 0, no ack or err seen by I.

Source files
------------

// File: rtl/moxie_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : moxie_wb_arbiter_pkg
// Description : Shared FSM encodings, timeout default and watchdog sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package moxie_wb_arbiter_pkg;

    // State encoding doubles as the one-hot grant vector (bit0 = I, bit1 = D).
    localparam logic [1:0] c_ST_IDLE  = 2'b00;
    localparam logic [1:0] c_ST_GNT_I = 2'b01;
    localparam logic [1:0] c_ST_GNT_D = 2'b10;

    localparam int unsigned c_TIMEOUT_DEFAULT = 255;

    function automatic int unsigned wdog_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/moxie_wb_arbiter_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : wb_watchdog
// Description : Saturating stall counter; flags the cycle it reaches the limit.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_watchdog
    import moxie_wb_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = c_TIMEOUT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned          c_CNT_W = wdog_width(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0]   c_LIMIT = c_CNT_W'(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0]   c_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]   c_ONE   = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            r_count <= '0;
        end else if (count_en && (r_count != c_LIMIT)) begin
            r_count <= r_count + c_ONE;
        end
    end

    // Fires on the stalled cycle whose increment brings the count to the limit.
    assign expired = count_en && (r_count >= c_LAST);

endmodule
`default_nettype wire

// File: rtl/moxie_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : moxie_wb_arbiter
// Description : Round-robin Wishbone arbiter for the I and D masters with
//               bus lock and an ack watchdog that aborts stalled transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module moxie_wb_arbiter
    import moxie_wb_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = c_TIMEOUT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wbm_I_cyc_i,
    input  logic        wbm_I_stb_i,
    input  logic [31:0] wbm_I_adr_i,
    output logic [15:0] wbm_I_dat_o,
    output logic        wbm_I_ack_o,
    output logic        wbm_I_err_o,
    input  logic        wbm_D_cyc_i,
    input  logic        wbm_D_stb_i,
    input  logic        wbm_D_we_i,
    input  logic [1:0]  wbm_D_sel_i,
    input  logic [31:0] wbm_D_adr_i,
    input  logic [15:0] wbm_D_dat_i,
    output logic [15:0] wbm_D_dat_o,
    output logic        wbm_D_ack_o,
    output logic        wbm_D_err_o,
    output logic        wbs_cyc_o,
    output logic        wbs_stb_o,
    output logic        wbs_we_o,
    output logic [1:0]  wbs_sel_o,
    output logic [31:0] wbs_adr_o,
    output logic [15:0] wbs_dat_o,
    input  logic [15:0] wbs_dat_i,
    input  logic        wbs_ack_i,
    output logic [1:0]  grant_o
);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_last_d;
    logic       w_own_i;
    logic       w_own_d;
    logic       w_own_stb;
    logic       w_ack;
    logic       w_expired;
    logic       w_abort;
    logic       w_grant_evt;

    assign w_own_i   = (r_state == c_ST_GNT_I);
    assign w_own_d   = (r_state == c_ST_GNT_D);
    assign w_own_stb = (w_own_i & wbm_I_cyc_i & wbm_I_stb_i)
                     | (w_own_d & wbm_D_cyc_i & wbm_D_stb_i);
    assign w_ack     = wbs_ack_i & (w_own_i | w_own_d) & ~rst_i;
    // Ack on the expiry cycle wins because count_en already excludes it.
    assign w_abort   = w_expired & (w_own_i | w_own_d) & ~rst_i;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (wbm_I_cyc_i && wbm_D_cyc_i) begin
                    w_state_nxt = r_last_d ? c_ST_GNT_I : c_ST_GNT_D;
                end else if (wbm_I_cyc_i) begin
                    w_state_nxt = c_ST_GNT_I;
                end else if (wbm_D_cyc_i) begin
                    w_state_nxt = c_ST_GNT_D;
                end
            end
            c_ST_GNT_I: begin
                if (!wbm_I_cyc_i || w_abort) w_state_nxt = c_ST_IDLE;
            end
            c_ST_GNT_D: begin
                if (!wbm_D_cyc_i || w_abort) w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    assign w_grant_evt = (r_state == c_ST_IDLE) && (w_state_nxt != c_ST_IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= c_ST_IDLE;
            r_last_d <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_evt) begin
                r_last_d <= (w_state_nxt == c_ST_GNT_D);
            end else if (w_abort) begin
                r_last_d <= w_own_d;
            end
        end
    end

    wb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear    (w_grant_evt | w_ack),
        .count_en (w_own_stb & ~wbs_ack_i),
        .expired  (w_expired)
    );

    always_comb begin
        wbs_cyc_o = 1'b0;
        wbs_stb_o = 1'b0;
        wbs_we_o  = 1'b0;
        wbs_sel_o = 2'b00;
        wbs_adr_o = 32'd0;
        wbs_dat_o = 16'd0;
        if (!rst_i) begin
            case (r_state)
                c_ST_GNT_I: begin
                    wbs_cyc_o = wbm_I_cyc_i & ~w_abort;
                    wbs_stb_o = wbm_I_stb_i & ~w_abort;
                    wbs_sel_o = 2'b11;
                    wbs_adr_o = wbm_I_adr_i;
                end
                c_ST_GNT_D: begin
                    wbs_cyc_o = wbm_D_cyc_i & ~w_abort;
                    wbs_stb_o = wbm_D_stb_i & ~w_abort;
                    wbs_we_o  = wbm_D_we_i;
                    wbs_sel_o = wbm_D_sel_i;
                    wbs_adr_o = wbm_D_adr_i;
                    wbs_dat_o = wbm_D_dat_i;
                end
                default: ;
            endcase
        end
    end

    assign wbm_I_dat_o = wbs_dat_i;
    assign wbm_D_dat_o = wbs_dat_i;
    assign wbm_I_ack_o = w_ack & w_own_i;
    assign wbm_D_ack_o = w_ack & w_own_d;
    assign wbm_I_err_o = w_abort & w_own_i;
    assign wbm_D_err_o = w_abort & w_own_d;
    assign grant_o     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_moxie_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_moxie_wb_arbiter
// Description : Directed scoreboard bench for moxie_wb_arbiter (timeout = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_moxie_wb_arbiter;

    logic        clk_i;
    logic        rst_i;
    logic        wbm_I_cyc_i, wbm_I_stb_i;
    logic [31:0] wbm_I_adr_i;
    logic [15:0] wbm_I_dat_o;
    logic        wbm_I_ack_o, wbm_I_err_o;
    logic        wbm_D_cyc_i, wbm_D_stb_i, wbm_D_we_i;
    logic [1:0]  wbm_D_sel_i;
    logic [31:0] wbm_D_adr_i;
    logic [15:0] wbm_D_dat_i;
    logic [15:0] wbm_D_dat_o;
    logic        wbm_D_ack_o, wbm_D_err_o;
    logic        wbs_cyc_o, wbs_stb_o, wbs_we_o;
    logic [1:0]  wbs_sel_o;
    logic [31:0] wbs_adr_o;
    logic [15:0] wbs_dat_o;
    logic [15:0] wbs_dat_i;
    logic        wbs_ack_i;
    logic [1:0]  grant_o;

    moxie_wb_arbiter #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .wbm_I_cyc_i (wbm_I_cyc_i),
        .wbm_I_stb_i (wbm_I_stb_i),
        .wbm_I_adr_i (wbm_I_adr_i),
        .wbm_I_dat_o (wbm_I_dat_o),
        .wbm_I_ack_o (wbm_I_ack_o),
        .wbm_I_err_o (wbm_I_err_o),
        .wbm_D_cyc_i (wbm_D_cyc_i),
        .wbm_D_stb_i (wbm_D_stb_i),
        .wbm_D_we_i  (wbm_D_we_i),
        .wbm_D_sel_i (wbm_D_sel_i),
        .wbm_D_adr_i (wbm_D_adr_i),
        .wbm_D_dat_i (wbm_D_dat_i),
        .wbm_D_dat_o (wbm_D_dat_o),
        .wbm_D_ack_o (wbm_D_ack_o),
        .wbm_D_err_o (wbm_D_err_o),
        .wbs_cyc_o   (wbs_cyc_o),
        .wbs_stb_o   (wbs_stb_o),
        .wbs_we_o    (wbs_we_o),
        .wbs_sel_o   (wbs_sel_o),
        .wbs_adr_o   (wbs_adr_o),
        .wbs_dat_o   (wbs_dat_o),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_ack_i   (wbs_ack_i),
        .grant_o     (grant_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        string       tag;
        logic [47:0] val;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic samp();
        @(negedge clk_i);
    endtask

    task automatic push(input string tag, input logic [47:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input logic [47:0] obs);
        exp_t e;
        compared++;
        if (sb.size() == 0) begin
            mismatched++;
            $error("FAIL sb_underflow: observed=%0h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                mismatched++;
                $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    // {grant, cyc, stb, we, sel}
    function automatic logic [6:0] ctl();
        return {grant_o, wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o};
    endfunction

    // {I ack, I err, D ack, D err}
    function automatic logic [3:0] ackv();
        return {wbm_I_ack_o, wbm_I_err_o, wbm_D_ack_o, wbm_D_err_o};
    endfunction

    task automatic do_reset();
        rst_i = 1'b1;
        {wbm_I_cyc_i, wbm_I_stb_i, wbm_D_cyc_i, wbm_D_stb_i, wbm_D_we_i, wbs_ack_i} = '0;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL tb_timeout: observed=hang expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst_i = 1'b1;
        {wbm_I_cyc_i, wbm_I_stb_i, wbm_D_cyc_i, wbm_D_stb_i, wbm_D_we_i, wbs_ack_i} = '0;
        wbm_I_adr_i = '0; wbm_D_sel_i = '0; wbm_D_adr_i = '0;
        wbm_D_dat_i = '0; wbs_dat_i = '0;

        // Reset: requests and acks arriving now must be ignored
        tick();
        wbm_I_cyc_i = 1'b1; wbm_I_stb_i = 1'b1; wbs_ack_i = 1'b1;
        push("rst_ctl", 0); push("rst_ack", 0);
        samp(); pop_cmp(ctl()); pop_cmp(ackv());
        tick();
        wbm_I_cyc_i = 1'b0; wbm_I_stb_i = 1'b0; wbs_ack_i = 1'b0;
        rst_i = 1'b0;

        // Single I read at 0x1000, ack on cycle 3
        wbm_I_cyc_i = 1'b1; wbm_I_stb_i = 1'b1; wbm_I_adr_i = 32'h1000;
        push("t1_c0_idle", 0);
        samp(); pop_cmp(ctl());
        tick();
        push("t1_c1_ctl", 7'b01_1_1_0_11); push("t1_c1_adr", 32'h1000);
        samp(); pop_cmp(ctl()); pop_cmp(wbs_adr_o);
        tick();
        push("t1_c2_noack", 0);
        samp(); pop_cmp(ackv());
        tick();
        wbs_ack_i = 1'b1; wbs_dat_i = 16'h1234;
        push("t1_c3_ack", 4'b1000); push("t1_c3_idat", 16'h1234); push("t1_c3_ddat", 16'h1234);
        samp(); pop_cmp(ackv()); pop_cmp(wbm_I_dat_o); pop_cmp(wbm_D_dat_o);
        tick();
        wbs_ack_i = 1'b0; wbm_I_cyc_i = 1'b0; wbm_I_stb_i = 1'b0;
        push("t1_c4_drop", 7'b01_0_0_0_11);
        samp(); pop_cmp(ctl());
        tick();
        push("t1_c5_idle", 0);
        samp(); pop_cmp(ctl());

        // Contention right after reset, then round-robin
        do_reset();
        wbm_I_cyc_i = 1'b1; wbm_I_stb_i = 1'b1;
        wbm_D_cyc_i = 1'b1; wbm_D_stb_i = 1'b1; wbm_D_we_i = 1'b0;
        wbm_D_sel_i = 2'b11; wbm_D_adr_i = 32'h2000;
        tick();
        wbs_ack_i = 1'b1;
        push("t2_e1_grant", 2'b01); push("t2_e1_ack", 4'b1000);
        samp(); pop_cmp(grant_o); pop_cmp(ackv());
        tick();
        wbs_ack_i = 1'b0; wbm_I_cyc_i = 1'b0; wbm_I_stb_i = 1'b0;
        push("t2_e2_ctl", 7'b01_0_0_0_11);
        samp(); pop_cmp(ctl());
        tick();
        wbm_I_cyc_i = 1'b1; wbm_I_stb_i = 1'b1;
        push("t2_e3_gap", 2'b00);
        samp(); pop_cmp(grant_o);
        tick();
        wbs_ack_i = 1'b1;
        push("t2_e4_grant_d", 2'b10); push("t2_e4_ack", 4'b0010);
        samp(); pop_cmp(grant_o); pop_cmp(ackv());
        tick();
        wbs_ack_i = 1'b0; wbm_D_cyc_i = 1'b0; wbm_D_stb_i = 1'b0;
        push("t2_e5_ctl", 7'b10_0_0_0_11);
        samp(); pop_cmp(ctl());
        tick();
        push("t2_e6_gap", 2'b00);
        samp(); pop_cmp(grant_o);
        tick();
        wbs_ack_i = 1'b1;
        push("t2_e7_grant_i", 2'b01); push("t2_e7_ack", 4'b1000);
        samp(); pop_cmp(grant_o); pop_cmp(ackv());
        tick();
        wbs_ack_i = 1'b0; wbm_I_cyc_i = 1'b0; wbm_I_stb_i = 1'b0;
        push("t2_e8_ack", 4'b0000);
        samp(); pop_cmp(ackv());
        tick();

        // D 4-beat write locks the bus while I keeps requesting
        wbm_I_cyc_i = 1'b1; wbm_I_stb_i = 1'b1;
        wbm_D_cyc_i = 1'b1; wbm_D_stb_i = 1'b1; wbm_D_we_i = 1'b1;
        wbm_D_sel_i = 2'b01; wbm_D_dat_i = 16'hBEEF; wbm_D_adr_i = 32'h3000;
        push("t3_f0_idle", 2'b00);
        samp(); pop_cmp(grant_o);
        tick();
        for (int b = 1; b <= 4; b++) begin
            wbs_ack_i = 1'b1;
            push($sformatf("t3_beat%0d_grant", b), 2'b10);
            push($sformatf("t3_beat%0d_ack", b), 4'b0010);
            samp(); pop_cmp(grant_o); pop_cmp(ackv());
            if (b == 1) begin
                push("t3_ctl", 7'b10_1_1_1_01); push("t3_dat", 16'hBEEF); push("t3_adr", 32'h3000);
                pop_cmp(ctl()); pop_cmp(wbs_dat_o); pop_cmp(wbs_adr_o);
            end
            tick();
        end
        wbs_ack_i = 1'b0; wbm_D_cyc_i = 1'b0; wbm_D_stb_i = 1'b0;
        push("t3_f5_ctl", 7'b10_0_0_1_01);
        samp(); pop_cmp(ctl());
        tick();
        push("t3_f6_gap", 2'b00);
        samp(); pop_cmp(grant_o);
        tick();
        wbs_ack_i = 1'b1;
        push("t3_f7_grant_i", 2'b01);
        samp(); pop_cmp(grant_o);
        tick();
        wbs_ack_i = 1'b0; wbm_I_cyc_i = 1'b0; wbm_I_stb_i = 1'b0;
        tick();

        // Watchdog: D strobe never acked -> err 4 cycles after stb
        wbm_D_cyc_i = 1'b1; wbm_D_stb_i = 1'b1; wbm_D_we_i = 1'b0;
        wbm_D_sel_i = 2'b11; wbm_D_adr_i = 32'h4000;
        tick();
        for (int k = 1; k <= 3; k++) begin
            push($sformatf("t4_g%0d_noerr", k), 4'b0000);
            samp(); pop_cmp(ackv());
            tick();
        end
        push("t4_g4_err", 4'b0001); push("t4_g4_ctl", 7'b10_0_0_0_11);
        samp(); pop_cmp(ackv()); pop_cmp(ctl());
        tick();
        wbm_D_cyc_i = 1'b0; wbm_D_stb_i = 1'b0;
        push("t4_g5_grant", 2'b00); push("t4_g5_ack", 4'b0000);
        samp(); pop_cmp(grant_o); pop_cmp(ackv());
        tick();

        // Ack on the would-be expiry cycle wins
        wbm_D_cyc_i = 1'b1; wbm_D_stb_i = 1'b1;
        tick();
        for (int k = 1; k <= 3; k++) begin
            push($sformatf("t5_h%0d_noerr", k), 4'b0000);
            samp(); pop_cmp(ackv());
            tick();
        end
        wbs_ack_i = 1'b1;
        push("t5_h4_ack", 4'b0010);
        samp(); pop_cmp(ackv());
        tick();
        wbs_ack_i = 1'b0;
        push("t5_h5_ack", 4'b0000); push("t5_h5_ctl", 7'b10_1_1_0_11);
        samp(); pop_cmp(ackv()); pop_cmp(ctl());
        tick();
        wbm_D_cyc_i = 1'b0; wbm_D_stb_i = 1'b0;
        tick();

        // Reset mid-transfer under GNT_I, with an ack arriving during reset
        wbm_I_cyc_i = 1'b1; wbm_I_stb_i = 1'b1; wbm_I_adr_i = 32'h5000;
        tick();
        push("t6_j1_grant", 2'b01);
        samp(); pop_cmp(grant_o);
        tick();
        rst_i = 1'b1; wbs_ack_i = 1'b1;
        push("t6_j2_cyc", 1'b0); push("t6_j2_ack", 4'b0000);
        samp(); pop_cmp(wbs_cyc_o); pop_cmp(ackv());
        tick();
        rst_i = 1'b0; wbs_ack_i = 1'b0;
        push("t6_j3_ctl", 0); push("t6_j3_ack", 4'b0000);
        samp(); pop_cmp(ctl()); pop_cmp(ackv());
        tick();
        wbm_I_cyc_i = 1'b0; wbm_I_stb_i = 1'b0;
        tick();

        compared++;
        assert (sb.size() == 0) else begin
            mismatched++;
            $error("FAIL sb_leftover: observed=%0d expected=0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
